// File: rtl/nes_clk_pkg.sv
// Shared types and default ratios for the NES clock-enable generator.
package nes_clk_pkg;

  localparam int unsigned DEF_NUM_CH = 2;
  localparam int unsigned DEF_CNT_W  = 5;

  // Channel 0 (CPU) in the LSBs, channel 1 (PPU) above it
  localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] NTSC_DIV_DEF = {5'd4, 5'd12};
  localparam logic [DEF_NUM_CH*DEF_CNT_W-1:0] PAL_DIV_DEF  = {5'd5, 5'd16};

  localparam logic MODE_NTSC = 1'b0;
  localparam logic MODE_PAL  = 1'b1;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_HOLD      = 2'd1,
    ST_RUN       = 2'd2,
    ST_SWITCH    = 2'd3
  } clk_state_e;

endpackage

// File: rtl/nes_clk_div_ch.sv
// One clock-enable channel: loadable divide ratio, wrap counter and terminal-count flag.
module nes_clk_div_ch #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             freeze,
  input  logic [CNT_W-1:0] div,
  output logic             tc_c
);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= div;
    end
  end

  // Clear wins over freeze so a lock loss or mode switch always restarts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= tc_c ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tc_c = (cnt == div_q - CNT_W'(1));

endmodule

// File: rtl/nes_clk_en_gen.sv
// NES master-clock enable generator: lock-qualified reset release, per-channel
// divided enables, align-point pulse and glitch-free NTSC/PAL switching.
module nes_clk_en_gen
  import nes_clk_pkg::*;
#(
  parameter int unsigned              NUM_CH      = DEF_NUM_CH,
  parameter int unsigned              CNT_W       = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0]  NTSC_DIV    = (NUM_CH*CNT_W)'(NTSC_DIV_DEF),
  parameter logic [NUM_CH*CNT_W-1:0]  PAL_DIV     = (NUM_CH*CNT_W)'(PAL_DIV_DEF),
  parameter int unsigned              HOLD_CYCLES = 16
) (
  input  logic              clk_master,
  input  logic              rst_ext,
  input  logic              mmcm_locked,
  input  logic              mode_pal,
  input  logic              halt,
  output logic [NUM_CH-1:0] ce,
  output logic              phase_zero,
  output logic              rst_sync,
  output logic              mode_active
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  if (NUM_CH == 0) begin : g_bad_num_ch
    $fatal(1, "nes_clk_en_gen: NUM_CH must be at least 1");
  end
  if (HOLD_CYCLES == 0) begin : g_bad_hold
    $fatal(1, "nes_clk_en_gen: HOLD_CYCLES must be at least 1");
  end

  clk_state_e        state;
  clk_state_e        state_nxt;
  logic              lock_meta;
  logic              lock_s;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done_c;
  logic [NUM_CH-1:0] tc;
  logic              align_c;
  logic              mode_differ_c;
  logic              switch_now_c;
  logic              ch_clear;
  logic              ch_load;
  logic              ch_freeze;
  logic [NUM_CH-1:0] ce_d;
  logic              pz_d;
  logic              rst_sync_d;
  logic              mode_d;

  // Two-flop synchronizer for the MMCM lock status
  always_ff @(posedge clk_master or posedge rst_ext) begin
    if (rst_ext) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= mmcm_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge clk_master or posedge rst_ext) begin
    if (rst_ext) begin
      hold_cnt <= '0;
    end else if (state == ST_HOLD) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // A CNT_W-bit field cannot exceed 2^CNT_W-1, so only a zero ratio needs rejecting
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CNT_W-1:0] DIV_N = NTSC_DIV[i*CNT_W +: CNT_W];
    localparam logic [CNT_W-1:0] DIV_P = PAL_DIV[i*CNT_W +: CNT_W];

    if (DIV_N == '0 || DIV_P == '0) begin : g_bad_div
      $fatal(1, "nes_clk_en_gen: divide ratio of zero on a channel");
    end

    nes_clk_div_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk    (clk_master),
      .rst    (rst_ext),
      .clear  (ch_clear),
      .load   (ch_load),
      .freeze (ch_freeze),
      .div    ((mode_pal == MODE_PAL) ? DIV_P : DIV_N),
      .tc_c   (tc[i])
    );
  end

  assign hold_done_c   = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
  assign align_c       = &tc;
  assign mode_differ_c = (mode_pal != mode_active);
  assign switch_now_c  = (state == ST_SWITCH) && lock_s && mode_differ_c && align_c && !halt;

  always_ff @(posedge clk_master or posedge rst_ext) begin
    if (rst_ext) begin
      state <= ST_WAIT_LOCK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT_LOCK: if (lock_s) state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (!lock_s)          state_nxt = ST_WAIT_LOCK;
        else if (hold_done_c) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s)            state_nxt = ST_WAIT_LOCK;
        else if (mode_differ_c) state_nxt = ST_SWITCH;
      end
      ST_SWITCH: begin
        if (!lock_s)             state_nxt = ST_WAIT_LOCK;
        else if (!mode_differ_c) state_nxt = ST_RUN;
        else if (switch_now_c)   state_nxt = ST_RUN;
      end
      default: state_nxt = ST_WAIT_LOCK;
    endcase
  end

  // Next values for the output registers and channel controls
  always_comb begin
    ch_clear   = 1'b0;
    ch_load    = 1'b0;
    ch_freeze  = 1'b1;
    ce_d       = '0;
    pz_d       = 1'b0;
    rst_sync_d = 1'b1;
    mode_d     = mode_active;
    unique case (state)
      ST_WAIT_LOCK: ch_clear = 1'b1;
      ST_HOLD: begin
        ch_clear = 1'b1;
        if (state_nxt == ST_RUN) begin
          ch_load    = 1'b1;
          mode_d     = (mode_pal == MODE_PAL) ? MODE_PAL : MODE_NTSC;
          rst_sync_d = 1'b0;
        end
      end
      ST_RUN, ST_SWITCH: begin
        if (!lock_s) begin
          ch_clear = 1'b1;
        end else begin
          rst_sync_d = 1'b0;
          ch_freeze  = halt;
          if (!halt) begin
            ce_d = tc;
            pz_d = align_c;
          end
          if (switch_now_c) begin
            ch_clear = 1'b1;
            ch_load  = 1'b1;
            mode_d   = (mode_pal == MODE_PAL) ? MODE_PAL : MODE_NTSC;
          end
        end
      end
      default: ch_clear = 1'b1;
    endcase
  end

  always_ff @(posedge clk_master or posedge rst_ext) begin
    if (rst_ext) begin
      ce          <= '0;
      phase_zero  <= 1'b0;
      rst_sync    <= 1'b1;
      mode_active <= MODE_NTSC;
    end else begin
      ce          <= ce_d;
      phase_zero  <= pz_d;
      rst_sync    <= rst_sync_d;
      mode_active <= mode_d;
    end
  end

endmodule
